// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg : shared state encoding and BCD digit limits for the        |
// |             countdown timer                                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam int BCD_W         = 4;
  localparam int SEC_UNITS_MAX = 9;
  localparam int TENS_SECS_MAX = 5;
  localparam int MIN_MAX       = 9;

  // Borrow reload value for a digit position: 0 = secs, 1 = tens_secs, else minutes.
  function automatic int digit_limit(input int pos);
    if (pos == 0) return SEC_UNITS_MAX;
    if (pos == 1) return TENS_SECS_MAX;
    return MIN_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_countdown_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_countdown_timer_if : key-entry/control strobes and count outputs  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bcd_countdown_timer_if
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2
);
  localparam int N = MIN_DIGITS + 2;

  logic [BCD_W-1:0]   digit;
  logic               digit_valid;
  logic               start;
  logic               stop;
  logic               cancel;
  logic [BCD_W*N-1:0] digits;
  logic               running;
  logic               zero;
  logic               done;
  logic               entry_err;

  modport master (
    output digit, digit_valid, start, stop, cancel,
    input  digits, running, zero, done, entry_err
  );

  modport slave (
    input  digit, digit_valid, start, stop, cancel,
    output digits, running, zero, done, entry_err
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_down.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_down : one BCD digit with shift-load and borrow decrement   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter int LIMIT = SEC_UNITS_MAX
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] shift_in,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out,
  output logic             is_zero
);

  logic [BCD_W-1:0] val_q, val_d;

  assign is_zero    = (val_q == '0);
  assign borrow_out = borrow_in && is_zero;
  assign q          = val_q;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (load) begin
      val_d = shift_in;
    end else if (borrow_in) begin
      val_d = is_zero ? BCD_W'(LIMIT) : val_q - BCD_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_countdown_timer : keypad-loaded mm..:ss BCD countdown with        |
// |                       run/pause control and done/entry-error pulses   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic                 CLK,
  input  logic                 clear,
  bcd_countdown_timer_if.slave tif
);

  localparam int N  = MIN_DIGITS + 2;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [N-1:0][BCD_W-1:0] w_dig;
  logic [N-1:0]            w_dig_zero;
  logic                    w_load;
  logic                    w_tick;
  logic                    w_zero;
  logic                    w_is_one;
  logic                    w_borrow_top;

  assign w_zero   = &w_dig_zero;
  assign w_is_one = (w_dig[0] == BCD_W'(1)) && (&w_dig_zero[N-1:1]);
  assign w_tick   = (state_q == ST_RUNNING) && (presc_q == C_PRESC_LAST) && !w_zero;

  for (genvar i = 0; i < N; i++) begin : g_digit
    logic [BCD_W-1:0] w_shift_in;
    logic             w_bin;
    logic             w_bout;

    if (i == 0) begin : g_lsd
      assign w_shift_in = tif.digit;
      assign w_bin      = w_tick;
    end else begin : g_upper
      assign w_shift_in = w_dig[i-1];
      assign w_bin      = g_digit[i-1].w_bout;
    end

    bcd_digit_down #(
      .LIMIT (digit_limit(i))
    ) u_digit (
      .CLK        (CLK),
      .clear      (clear),
      .clr        (tif.cancel),
      .load       (w_load),
      .shift_in   (w_shift_in),
      .borrow_in  (w_bin),
      .q          (w_dig[i]),
      .borrow_out (w_bout),
      .is_zero    (w_dig_zero[i])
    );
  end

  // Never set while running (count is nonzero there); folded in as a zero-reach guard.
  assign w_borrow_top = g_digit[N-1].w_bout;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    w_load  = 1'b0;
    if (tif.cancel) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      if (state_q == ST_RUNNING) begin
        presc_d = w_tick ? '0 : presc_q + PW'(1);
      end
      // Reaching zero overrides a coincident stop.
      if (w_tick && (w_is_one || w_borrow_top)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else if (tif.stop) begin
        if (state_q == ST_RUNNING) state_d = ST_PAUSED;
      end else if (tif.start) begin
        if (state_q == ST_IDLE && !w_zero) begin
          state_d = ST_RUNNING;
          presc_d = '0;
        end else if (state_q == ST_PAUSED) begin
          state_d = ST_RUNNING;
        end
      end else if (tif.digit_valid) begin
        if (state_q == ST_IDLE && tif.digit <= BCD_W'(SEC_UNITS_MAX) &&
            w_dig[0] <= BCD_W'(TENS_SECS_MAX)) begin
          w_load = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tif.digits    = w_dig;
  assign tif.running   = (state_q == ST_RUNNING);
  assign tif.zero      = w_zero;
  assign tif.done      = done_q;
  assign tif.entry_err = err_q;

endmodule
`default_nettype wire
